// File: rtl/ser_rx_align_if.sv
// Serial receive link: bit input side (enable/data_in/realign) and aligned word output side.
// Latency: none (wires only).
// Backpressure: none; the receiver cannot stall, and consumers must take every data_valid pulse.
interface ser_rx_align_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             data_in;
  logic             realign;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             is_sync;
  logic             locked;
  logic [15:0]      word_count;

  // Source side: drives serial bits and realign, observes the aligned words.
  modport master (
    output enable, data_in, realign,
    input  data_out, data_valid, is_sync, locked, word_count
  );

  // Receiver side.
  modport slave (
    input  enable, data_in, realign,
    output data_out, data_valid, is_sync, locked, word_count
  );
endinterface

// File: rtl/ser_rx_align.sv
// Serial-to-parallel receiver: hunts the sync word at any bit offset, confirms it, then emits aligned words.
// Latency: data_valid/data_out are registered on the edge that samples the word's last bit.
// Backpressure: none; enable=0 freezes all state, and realign drops lock back to hunting.
module ser_rx_align #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 8'hBC,
  parameter int               LOCK_COUNT = 4
) (
  input logic          clock_160,
  input logic          reset,
  ser_rx_align_if.slave rx
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int HW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [HW-1:0] LAST_HIT = HW'(LOCK_COUNT - 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [HW-1:0]    hits;
  logic             word_end;
  logic             sync_hit;

  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             is_sync_q;
  logic             locked_q;
  logic [15:0]      word_count_q;

  // The comparisons always look at the window including the bit arriving this cycle.
  assign shreg_nxt = {shreg[WIDTH-2:0], rx.data_in};
  assign word_end  = (bit_cnt == LAST_BIT);
  assign sync_hit  = (shreg_nxt == SYNC_WORD);

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = data_valid_q;
  assign rx.is_sync    = is_sync_q;
  assign rx.locked     = locked_q;
  assign rx.word_count = word_count_q;

  // Alignment FSM, shift register and word emission; realign overrides the FSM but not the shift.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      state        <= HUNT;
      shreg        <= '0;
      bit_cnt      <= '0;
      hits         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      is_sync_q    <= 1'b0;
      locked_q     <= 1'b0;
      word_count_q <= '0;
    end else begin
      data_valid_q <= 1'b0;
      is_sync_q    <= 1'b0;
      if (rx.enable) begin
        shreg <= shreg_nxt;
      end
      if (rx.realign) begin
        // shreg keeps shifting so a sync overlapping the realign point is still found.
        state    <= HUNT;
        hits     <= '0;
        bit_cnt  <= '0;
        locked_q <= 1'b0;
      end else if (rx.enable) begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              hits    <= HW'(1);
              bit_cnt <= '0;
              if (LOCK_COUNT == 1) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (word_end) begin
              bit_cnt <= '0;
              if (sync_hit) begin
                hits <= hits + 1'b1;
                if (hits == LAST_HIT) begin
                  // The sync word completing lock is not emitted.
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                state <= HUNT;
                hits  <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (word_end) begin
              bit_cnt      <= '0;
              data_out_q   <= shreg_nxt;
              data_valid_q <= 1'b1;
              is_sync_q    <= sync_hit;
              word_count_q <= word_count_q + 16'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state    <= HUNT;
            hits     <= '0;
            bit_cnt  <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ser_rx_align.sv
// Self-checking bench for ser_rx_align: word-level reference model compared every cycle, plus directed literals.
// Latency: model outputs are registered like the DUT and compared on the falling edge.
// Backpressure: none; stimulus exercises enable gaps, realign and reset at random points.
module tb_ser_rx_align;

  localparam int         WIDTH      = 8;
  localparam logic [7:0] SYNC       = 8'hBC;
  localparam int         LOCK_COUNT = 4;

  logic clock_160 = 1'b0;
  logic reset     = 1'b1;

  // 10 ns clock.
  always #5 clock_160 = ~clock_160;

  ser_rx_align_if #(.WIDTH(WIDTH)) rx();

  ser_rx_align #(
    .WIDTH     (WIDTH),
    .SYNC_WORD (SYNC),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clock_160(clock_160),
    .reset    (reset),
    .rx       (rx)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model: mode 0 = hunting, 1 = confirming, 2 = locked.
  int         m_mode   = 0;
  int         m_window = 0;
  int         m_nsync  = 0;
  bit         m_bits[$];
  logic [7:0] m_dout   = '0;
  bit         m_valid  = 1'b0;
  bit         m_sync   = 1'b0;
  bit         m_locked = 1'b0;
  logic [15:0] m_wc    = '0;

  logic [7:0] emit_q[$];
  bit         emit_sync_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] emit_at(input int i);
    if (i < emit_q.size()) return {24'd0, emit_q[i]};
    return 32'hFFFF;
  endfunction

  // Advances the model by one clock edge with the inputs applied on that edge.
  task automatic model_step(input bit rst, input bit en, input bit d, input bit ra);
    int word;
    if (rst) begin
      m_mode = 0; m_window = 0; m_nsync = 0; m_bits.delete();
      m_dout = '0; m_valid = 1'b0; m_sync = 1'b0; m_locked = 1'b0; m_wc = '0;
      return;
    end
    m_valid = 1'b0;
    m_sync  = 1'b0;
    if (en) m_window = (m_window * 2 + int'(d)) % (1 << WIDTH);
    if (ra) begin
      m_mode = 0; m_nsync = 0; m_bits.delete();
    end else if (en) begin
      if (m_mode == 0) begin
        if (m_window == int'(SYNC)) begin
          m_nsync = 1;
          m_bits.delete();
          m_mode = (m_nsync >= LOCK_COUNT) ? 2 : 1;
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == WIDTH) begin
          word = 0;
          foreach (m_bits[k]) word = word * 2 + int'(m_bits[k]);
          m_bits.delete();
          if (m_mode == 1) begin
            if (word == int'(SYNC)) begin
              m_nsync++;
              if (m_nsync == LOCK_COUNT) m_mode = 2;
            end else begin
              m_mode = 0; m_nsync = 0;
            end
          end else begin
            m_dout  = 8'(word);
            m_valid = 1'b1;
            m_sync  = (word == int'(SYNC));
            m_wc    = m_wc + 16'd1;
          end
        end
      end
    end
    m_locked = (m_mode == 2);
  endtask

  task automatic drive(input bit rst, input bit en, input bit d, input bit ra);
    @(negedge clock_160);
    reset      = rst;
    rx.enable  = en;
    rx.data_in = d;
    rx.realign = ra;
    @(posedge clock_160);
    model_step(rst, en, d, ra);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) drive(1'b0, 1'b1, b[i], 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_case();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    emit_q.delete();
    emit_sync_q.delete();
  endtask

  // Every-cycle comparison of DUT outputs against the model; also logs emitted words.
  always @(negedge clock_160) begin
    if (check_en) begin
      check("data_out",   32'(rx.data_out),   32'(m_dout));
      check("data_valid", 32'(rx.data_valid), 32'(m_valid));
      check("is_sync",    32'(rx.is_sync),    32'(m_sync));
      check("locked",     32'(rx.locked),     32'(m_locked));
      check("word_count", 32'(rx.word_count), 32'(m_wc));
      if (rx.data_valid === 1'b1) begin
        emit_q.push_back(rx.data_out);
        emit_sync_q.push_back(rx.is_sync);
      end
    end
  end

  initial begin
    logic [7:0] cur;
    int         left;
    int         r;
    bit         rst, en, d, ra;

    rx.enable  = 1'b0;
    rx.data_in = 1'b0;
    rx.realign = 1'b0;

    // 1: reset held with enable and toggling data.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_en = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("t1_data_out",   32'(rx.data_out),   32'h0);
    check("t1_data_valid", 32'(rx.data_valid), 32'h0);
    check("t1_locked",     32'(rx.locked),     32'h0);
    check("t1_word_count", 32'(rx.word_count), 32'h0);

    // 2: lock on four syncs, then two data words.
    start_case();
    repeat (4) send_byte(SYNC);
    #1 check("t2_locked", 32'(rx.locked), 32'h1);
    send_byte(8'hBB);
    send_byte(8'h12);
    idle();
    #1;
    check("t2_n_words",  32'(emit_q.size()), 32'd2);
    check("t2_word0",    emit_at(0), 32'hBB);
    check("t2_word1",    emit_at(1), 32'h12);
    check("t2_sync0",    32'(emit_sync_q.size() > 0 && emit_sync_q[0]), 32'h0);
    check("t2_wc",       32'(rx.word_count), 32'd2);

    // 3: sync found after three junk bits.
    start_case();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) send_byte(SYNC);
    send_byte(8'hA5);
    idle();
    #1;
    check("t3_n_words", 32'(emit_q.size()), 32'd1);
    check("t3_word0",   emit_at(0), 32'hA5);

    // 4: bad sync while confirming, then relock.
    start_case();
    send_byte(SYNC);
    send_byte(SYNC);
    send_byte(8'h3C);
    #1 check("t4_unlocked", 32'(rx.locked), 32'h0);
    repeat (4) send_byte(SYNC);
    #1 check("t4_relocked", 32'(rx.locked), 32'h1);
    send_byte(8'h55);
    idle();
    #1;
    check("t4_n_words", 32'(emit_q.size()), 32'd1);
    check("t4_word0",   emit_at(0), 32'h55);

    // 5: enable gaps inside a word.
    start_case();
    repeat (4) send_byte(SYNC);
    cur = 8'hBB;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b0, 1'b1, cur[i], 1'b0);
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    idle();
    #1;
    check("t5_n_words", 32'(emit_q.size()), 32'd1);
    check("t5_data_out", 32'(rx.data_out), 32'hBB);

    // 6: realign mid-word, relock, then reset mid-word.
    start_case();
    repeat (4) send_byte(SYNC);
    repeat (4) drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("t6_realign_locked", 32'(rx.locked), 32'h0);
    repeat (4) send_byte(SYNC);
    #1 check("t6_relocked", 32'(rx.locked), 32'h1);
    check("t6_no_words", 32'(emit_q.size()), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("t6_rst_locked", 32'(rx.locked),     32'h0);
    check("t6_rst_wc",     32'(rx.word_count), 32'h0);
    check("t6_rst_dout",   32'(rx.data_out),   32'h0);

    // Random phase: mostly sync words, occasional bit slips, gaps, realigns and resets.
    left = 0;
    cur  = '0;
    for (int c = 0; c < 4000; c++) begin
      r   = int'($urandom_range(0, 999));
      rst = (r < 1);
      ra  = (r >= 1 && r < 3);
      en  = ($urandom_range(0, 9) < 8);
      d   = 1'b0;
      if (en) begin
        if (left == 0) begin
          cur  = ($urandom_range(0, 3) != 0) ? SYNC : 8'($urandom);
          left = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 7)) : 8;
        end
        d = cur[left-1];
        left--;
      end
      drive(rst, en, d, ra);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
